systolic_feed_sequencer: RTL

//  Job-level controller for the two data extractors (matrix A west feed, matrix B north feed) and the systolic array.
//  On start it flushes both extractors and loads their base addresses and matrix width.
//  It gates each extractor's enable so both stay in lock-step per diagonal wavefront, and pulses the array shift once per joint wavefront.
//  It then drains the array and reports done. Sits between the host/command block and the extractor + PE-array datapath.

---
 rtl/systolic_feed_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_feed_sequencer.sv
// Job-level sequencer for the A/B operand extractors and the systolic array.
// It keeps the two extractors in lock-step per wavefront, then drains the array and reports completion.
module systolic_feed_sequencer #(
    parameter int FIF0_DEPTH    = 256,
    parameter int MAX_SIZE      = 16,
    parameter int SYSTOLIC_SIZE = 16,
    parameter int DRAIN_CYCLES  = 32,
    localparam int AW  = $clog2(FIF0_DEPTH),
    localparam int MW  = $clog2(MAX_SIZE) + 1,
    localparam int WCW = $clog2(2 * SYSTOLIC_SIZE),
    localparam int DCW = $clog2(DRAIN_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr_a_in,
    input  logic [AW-1:0] base_addr_b_in,
    input  logic [MW-1:0] matrix_width_in,
    input  logic          ext_a_completed,
    input  logic          ext_b_completed,
    output logic          ext_flush,
    output logic          ext_a_enable,
    output logic          ext_b_enable,
    output logic [AW-1:0] ext_a_base_addr,
    output logic [AW-1:0] ext_b_base_addr,
    output logic [MW-1:0] ext_matrix_width,
    output logic          pe_shift_en,
    output logic [WCW-1:0] wavefront_cnt,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          sync_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } state_t;

    localparam logic [WCW-1:0] LAST_WF    = WCW'(2 * SYSTOLIC_SIZE - 2);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    state_t         state_r, state_s;
    logic           a_flag_r, a_flag_s, b_flag_r, b_flag_s;
    logic [DCW-1:0] drain_r, drain_s;
    logic [WCW-1:0] wcnt_r, wcnt_s;
    logic           serr_r, serr_s;
    logic [AW-1:0]  addr_a_r, addr_a_s, addr_b_r, addr_b_s;
    logic [MW-1:0]  width_r, width_s;
    logic           flush_r, ena_r, enb_r, shift_r, busy_r, done_r, aborted_r;
    logic           sync_s;

    // Next-state, flag, counter and latched-configuration logic
    always_comb begin
        state_s  = state_r;
        a_flag_s = a_flag_r;
        b_flag_s = b_flag_r;
        drain_s  = '0;
        wcnt_s   = wcnt_r;
        serr_s   = serr_r;
        addr_a_s = addr_a_r;
        addr_b_s = addr_b_r;
        width_s  = width_r;
        sync_s   = (a_flag_r | ext_a_completed) & (b_flag_r | ext_b_completed);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = FLUSH;
                    addr_a_s = base_addr_a_in;
                    addr_b_s = base_addr_b_in;
                    width_s  = matrix_width_in;
                    wcnt_s   = '0;
                    serr_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            FLUSH: begin
                if (abort) state_s = ABORT;
                else       state_s = FEED;
            end
            FEED: begin
                if (abort) begin
                    state_s = ABORT;
                end else begin
                    // A completion on an already-finished extractor means the pair lost step
                    serr_s = serr_r | (ext_a_completed & a_flag_r) | (ext_b_completed & b_flag_r);
                    if (sync_s) begin
                        a_flag_s = 1'b0;
                        b_flag_s = 1'b0;
                        wcnt_s   = wcnt_r + WCW'(1);
                        if (wcnt_r == LAST_WF) state_s = DRAIN;
                        else                   state_s = FEED;
                    end else begin
                        a_flag_s = a_flag_r | ext_a_completed;
                        b_flag_s = b_flag_r | ext_b_completed;
                    end
                end
            end
            DRAIN: begin
                if (abort)                    state_s = ABORT;
                else if (drain_r == DRAIN_LAST) state_s = DONE;
                else                          drain_s = drain_r + DCW'(1);
            end
            DONE: begin
                if (abort) state_s = ABORT;
                else       state_s = IDLE;
            end
            ABORT: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (state_s != FEED) begin
            a_flag_s = 1'b0;
            b_flag_s = 1'b0;
        end else begin
            a_flag_s = a_flag_s;
        end
    end

    // State, flags, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_flag_r  <= 1'b0;
            b_flag_r  <= 1'b0;
            drain_r   <= '0;
            wcnt_r    <= '0;
            serr_r    <= 1'b0;
            addr_a_r  <= '0;
            addr_b_r  <= '0;
            width_r   <= '0;
            flush_r   <= 1'b0;
            ena_r     <= 1'b0;
            enb_r     <= 1'b0;
            shift_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            a_flag_r  <= a_flag_s;
            b_flag_r  <= b_flag_s;
            drain_r   <= drain_s;
            wcnt_r    <= wcnt_s;
            serr_r    <= serr_s;
            addr_a_r  <= addr_a_s;
            addr_b_r  <= addr_b_s;
            width_r   <= width_s;
            flush_r   <= (state_s == FLUSH) || (state_s == ABORT);
            ena_r     <= (state_s == FEED) && !a_flag_s;
            enb_r     <= (state_s == FEED) && !b_flag_s;
            // The shift for the final wavefront is the first drain pulse
            shift_r   <= (state_s == DRAIN) || ((state_r == FEED) && sync_s && (state_s == FEED));
            busy_r    <= (state_s == FLUSH) || (state_s == FEED) || (state_s == DRAIN);
            done_r    <= (state_s == DONE);
            aborted_r <= (state_s == ABORT);
        end
    end

    assign ext_flush        = flush_r;
    assign ext_a_enable     = ena_r;
    assign ext_b_enable     = enb_r;
    assign ext_a_base_addr  = addr_a_r;
    assign ext_b_base_addr  = addr_b_r;
    assign ext_matrix_width = width_r;
    assign pe_shift_en      = shift_r;
    assign wavefront_cnt    = wcnt_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign aborted          = aborted_r;
    assign sync_err         = serr_r;

endmodule
